// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if: configuration inputs and divided outputs of the clock divider
interface multi_clock_divider_if #(
  parameter int NB_DIVIDER = 24,
  parameter int N_CH       = 4
);
  logic [N_CH-1:0]            i_enable;
  logic [N_CH*NB_DIVIDER-1:0] i_divider;
  logic [N_CH*NB_DIVIDER-1:0] i_high;
  logic                       i_load;
  logic                       i_sync;
  logic [N_CH-1:0]            o_clk;
  logic [N_CH-1:0]            o_tick;
  logic                       o_load_pending;
  modport master (
    output i_enable, i_divider, i_high, i_load, i_sync,
    input  o_clk, o_tick, o_load_pending
  );
  modport slave (
    input  i_enable, i_divider, i_high, i_load, i_sync,
    output o_clk, o_tick, o_load_pending
  );
endinterface

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N_CH double-buffered programmable clock/tick generators with global sync
module multi_clock_divider #(
  parameter int NB_DIVIDER = 24,
  parameter int N_CH       = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  multi_clock_divider_if.slave bus
);
  typedef logic [N_CH-1:0][NB_DIVIDER-1:0] vec_t;
  vec_t cnt_q, cnt_d, d_q, d_d, h_q, h_d, sd_q, sd_d, sh_q, sh_d, div, high;
  logic [N_CH-1:0] en_q, en_d, pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, bnd;
  logic lp_q, lp_d;
  assign div  = bus.i_divider;
  assign high = bus.i_high;
  always_comb begin
    bnd    = '0;
    cnt_d  = cnt_q;
    d_d    = d_q;
    h_d    = h_q;
    sd_d   = sd_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    clk_d  = '0;
    tick_d = '0;
    en_d   = bus.i_enable;
    for (int c = 0; c < N_CH; c++) begin
      // a boundary is any edge where the channel restarts at count 0 and may take new config
      bnd[c]    = !bus.i_enable[c] || !en_q[c] || bus.i_sync || (cnt_q[c] == d_q[c]);
      sd_d[c]   = bus.i_load ? div[c] : sd_q[c];
      sh_d[c]   = bus.i_load ? high[c] : sh_q[c];
      d_d[c]    = !bnd[c] ? d_q[c] : bus.i_load ? div[c] : pend_q[c] ? sd_q[c] : d_q[c];
      h_d[c]    = !bnd[c] ? h_q[c] : bus.i_load ? high[c] : pend_q[c] ? sh_q[c] : h_q[c];
      pend_d[c] = (bus.i_load || pend_q[c]) && !bnd[c];
      cnt_d[c]  = bnd[c] ? '0 : cnt_q[c] + 1'b1;
      tick_d[c] = bus.i_enable[c] && (cnt_d[c] == d_d[c]);
      clk_d[c]  = bus.i_enable[c] && (cnt_d[c] < h_d[c]);
    end
    lp_d = |pend_d;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      d_q    <= '0;
      h_q    <= '0;
      sd_q   <= '0;
      sh_q   <= '0;
      en_q   <= '0;
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      h_q    <= h_d;
      sd_q   <= sd_d;
      sh_q   <= sh_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      lp_q   <= lp_d;
    end
  end
  assign bus.o_clk          = clk_q;
  assign bus.o_tick         = tick_q;
  assign bus.o_load_pending = lp_q;
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed vector table plus hand sequences for reload, sync and reset
module tb_multi_clock_divider;
  typedef struct {
    logic        en;
    logic        ld;
    logic [23:0] d;
    logic [23:0] h;
    logic        ck;
    logic        tk;
    logic        pd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total  = 0;
  vec_t tbl[$];
  multi_clock_divider_if #(.NB_DIVIDER(24), .N_CH(4)) bus ();
  multi_clock_divider #(.NB_DIVIDER(24), .N_CH(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic en, logic ld, int d, int h, logic ck, logic tk, logic pd);
    vec_t v;
    v.en = en; v.ld = ld; v.d = d[23:0]; v.h = h[23:0]; v.ck = ck; v.tk = tk; v.pd = pd;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [11:0] e_clk, e_tick, e_pend;
    bus.i_enable = '0; bus.i_load = 0; bus.i_sync = 0; bus.i_divider = '0; bus.i_high = '0;
    repeat (2) cyc();
    chk("reset_clk", bus.o_clk, 0);
    chk("reset_tick", bus.o_tick, 0);
    chk("reset_pend", bus.o_load_pending, 0);
    rst = 0;
    cyc();
    chk("idle_clk", bus.o_clk, 0);
    chk("idle_tick", bus.o_tick, 0);
    // D=0 from reset, then 1100 pattern, bypass load at boundary, deferred H change
    repeat (3) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 2, 0, 0, 0));
    repeat (2) begin
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    end
    tbl.push_back(mk(1, 1, 3, 5, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      bus.i_enable  = {3'b0, tbl[i].en};
      bus.i_load    = tbl[i].ld;
      bus.i_divider = {4{tbl[i].d}};
      bus.i_high    = {4{tbl[i].h}};
      cyc();
      chk($sformatf("tbl%0d_clk", i), bus.o_clk, {3'b0, tbl[i].ck});
      chk($sformatf("tbl%0d_tick", i), bus.o_tick, {3'b0, tbl[i].tk});
      chk($sformatf("tbl%0d_pend", i), bus.o_load_pending, tbl[i].pd);
    end
    bus.i_load = 0;
    // reload mid-period: old 4-cycle period finishes, then 8-cycle 11110000
    bus.i_divider = {4{24'd3}}; bus.i_high = {4{24'd2}}; bus.i_load = 1;
    cyc();
    bus.i_load = 0; bus.i_enable = 4'b0001;
    cyc();
    bus.i_divider = {4{24'd7}}; bus.i_high = {4{24'd4}}; bus.i_load = 1;
    e_clk = 12'b100111100001; e_tick = 12'b001000000010; e_pend = 12'b111000000000;
    for (int i = 11; i >= 0; i--) begin
      cyc();
      bus.i_load = 0;
      chk($sformatf("reload%0d_clk", 11 - i), bus.o_clk[0], e_clk[i]);
      chk($sformatf("reload%0d_tick", 11 - i), bus.o_tick[0], e_tick[i]);
      chk($sformatf("reload%0d_pend", 11 - i), bus.o_load_pending, e_pend[i]);
    end
    // two channels started out of phase, then aligned by sync
    bus.i_enable = '0;
    bus.i_divider = {24'd0, 24'd0, 24'd9, 24'd4}; bus.i_high = {24'd0, 24'd0, 24'd5, 24'd2};
    bus.i_load = 1;
    cyc();
    bus.i_load = 0; bus.i_enable = 4'b0001;
    repeat (3) cyc();
    bus.i_enable = 4'b0011;
    repeat (5) cyc();
    bus.i_sync = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      bus.i_sync = 0;
      chk($sformatf("sync%0d_tick", k), bus.o_tick, {2'b0, k % 10 == 9, k % 5 == 4});
      chk($sformatf("sync%0d_clk", k), bus.o_clk, {2'b0, k % 10 < 5, k % 5 < 2});
    end
    cyc();
    bus.i_divider = {24'd0, 24'd0, 24'd9, 24'd1}; bus.i_high = {24'd0, 24'd0, 24'd5, 24'd1};
    bus.i_load = 1;
    cyc();
    bus.i_load = 0;
    chk("sync_apply_pend_before", bus.o_load_pending, 1);
    bus.i_sync = 1;
    cyc();
    bus.i_sync = 0;
    chk("sync_apply_pend_after", bus.o_load_pending, 0);
    chk("sync_apply_clk0", bus.o_clk, 4'b0011);
    chk("sync_apply_tick0", bus.o_tick, 4'b0000);
    cyc();
    chk("sync_apply_clk1", bus.o_clk, 4'b0010);
    chk("sync_apply_tick1", bus.o_tick, 4'b0001);
    cyc();
    chk("sync_apply_clk2", bus.o_clk, 4'b0011);
    chk("sync_apply_tick2", bus.o_tick, 4'b0000);
    // asynchronous reset in the middle of a period with a reload pending
    bus.i_enable = '0;
    bus.i_divider = {4{24'd7}}; bus.i_high = {4{24'd4}}; bus.i_load = 1;
    cyc();
    bus.i_load = 0; bus.i_enable = 4'b0001;
    cyc();
    bus.i_load = 1;
    cyc();
    bus.i_load = 0;
    cyc();
    chk("prerst_clk", bus.o_clk[0], 1);
    chk("prerst_pend", bus.o_load_pending, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_clk", bus.o_clk, 0);
    chk("async_rst_tick", bus.o_tick, 0);
    chk("async_rst_pend", bus.o_load_pending, 0);
    cyc();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("postrst%0d_tick", i), bus.o_tick[0], 1);
      chk($sformatf("postrst%0d_clk", i), bus.o_clk[0], 0);
      chk($sformatf("postrst%0d_pend", i), bus.o_load_pending, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
